// File: rtl/if_fetch_stage_if.sv
// Bundle between the fetch stage, the instruction memory and the IF/ID register.
// Handshake: a fetch transfers on any cycle with imem_req & imem_gnt; while imem_gnt=0
// imem_req and imem_addr stay put, and imem_rvalid/imem_rdata follow each transfer by one cycle.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_vld;

  modport master (
    output imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_vld,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, IF_ID_pc, IF_ID_inst, IF_ID_vld,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/gnt fetch port, 1-entry skid buffer and IF/ID register.
// Optional macro IF_MISALIGN_CHK_EN adds if_misalign and word-aligns redirect targets.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_IF,
  input  logic               CTRL_IF_jmp_vld,
  input  logic [31:0]        CTRL_IF_jmp_addr,
  if_fetch_stage_if.master   bus,
  output logic [1:0]         o_dbg_state
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic               if_misalign
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight;
  logic        r_kill;
  logic        r_skid_vld;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_vld;

  logic        w_req;
  logic        w_accept;
  logic        w_rsp;
  logic [31:0] w_jmp_target;

`ifdef IF_MISALIGN_CHK_EN
  logic r_misalign;
  logic w_misalign;
  assign w_misalign   = |CTRL_IF_jmp_addr[1:0];
  assign w_jmp_target = {CTRL_IF_jmp_addr[31:2], 2'b00};
  assign if_misalign  = r_misalign;
`else
  assign w_jmp_target = CTRL_IF_jmp_addr;
`endif

  // A full skid slot blocks new fetches so at most one response is ever parked.
  assign w_req    = ~rst & (r_state == ST_RUN) & ~hold_IF & ~r_skid_vld & ~CTRL_IF_jmp_vld;
  assign w_accept = w_req & bus.imem_gnt;
  assign w_rsp    = bus.imem_rvalid & r_inflight & ~r_kill;

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_pc;
  assign bus.IF_ID_pc   = r_id_pc;
  assign bus.IF_ID_inst = r_id_inst;
  assign bus.IF_ID_vld  = r_id_vld;
  assign o_dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
      r_skid_vld    <= 1'b0;
      r_skid_inst   <= NOP_INST;
      r_skid_pc     <= RESET_PC;
      r_id_pc       <= RESET_PC;
      r_id_inst     <= NOP_INST;
      r_id_vld      <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_pc          <= r_pc + 32'd4;
        r_inflight_pc <= r_pc;
      end
      if (bus.imem_rvalid & r_inflight) begin
        r_kill <= 1'b0;
      end
`ifdef IF_MISALIGN_CHK_EN
      r_misalign <= 1'b0;
`endif

      if (CTRL_IF_jmp_vld) begin
        // A response landing in the redirect cycle is simply not presented; kill only
        // covers a request whose response is still to come.
        r_state    <= ST_RUN;
        r_pc       <= w_jmp_target;
        r_kill     <= r_inflight & ~bus.imem_rvalid;
        r_skid_vld <= 1'b0;
        r_id_vld   <= 1'b0;
        r_id_inst  <= NOP_INST;
`ifdef IF_MISALIGN_CHK_EN
        r_misalign <= w_misalign;
`endif
      end else if (hold_IF) begin
        case (r_state)
          ST_BOOT: r_state <= ST_RUN;
          default: r_state <= ST_HOLD;
        endcase
        if (w_rsp) begin
          r_skid_vld  <= 1'b1;
          r_skid_inst <= bus.imem_rdata;
          r_skid_pc   <= r_inflight_pc;
        end
      end else begin
        r_state <= ST_RUN;
        if (r_skid_vld) begin
          r_id_vld   <= 1'b1;
          r_id_inst  <= r_skid_inst;
          r_id_pc    <= r_skid_pc;
          r_skid_vld <= 1'b0;
        end else if (w_rsp) begin
          r_id_vld  <= 1'b1;
          r_id_inst <= bus.imem_rdata;
          r_id_pc   <= r_inflight_pc;
        end else begin
          r_id_vld  <= 1'b0;
          r_id_inst <= NOP_INST;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; the memory answers every accepted fetch one cycle later with addr+1.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        hold_IF;
  logic        jmp_vld;
  logic [31:0] jmp_addr;
  logic [1:0]  dbg_state;
`ifdef IF_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  int n_pass;
  int n_total;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .hold_IF          (hold_IF),
    .CTRL_IF_jmp_vld  (jmp_vld),
    .CTRL_IF_jmp_addr (jmp_addr),
    .bus              (bus),
    .o_dbg_state      (dbg_state)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .if_misalign      (if_misalign)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = bus.imem_req & bus.imem_gnt;
    a   = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rvalid = acc;
    bus.imem_rdata  = a + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; hold_IF = 1'b0; jmp_vld = 1'b0; jmp_addr = 32'h0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; hold_IF = 1'b0; jmp_vld = 1'b0; jmp_addr = 32'h0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    step();
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", bus.imem_req); else n_pass++;
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL rst_vld: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    n_total++; if (bus.IF_ID_inst !== NOP) $display("FAIL rst_inst: got %h exp %h", bus.IF_ID_inst, NOP); else n_pass++;
    n_total++; if (bus.IF_ID_pc !== 32'h0) $display("FAIL rst_pc: got %h exp 0", bus.IF_ID_pc); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL boot_req: got %b exp 0", bus.imem_req); else n_pass++;
    n_total++; if (dbg_state !== 2'd0) $display("FAIL boot_state: got %0d exp 0", dbg_state); else n_pass++;
    step();
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %b exp 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL first_addr: got %h exp 0", bus.imem_addr); else n_pass++;
    n_total++; if (dbg_state !== 2'd1) $display("FAIL run_state: got %0d exp 1", dbg_state); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    step();
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL stream_c3_vld: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h4) $display("FAIL stream_c3_addr: got %h exp 4", bus.imem_addr); else n_pass++;
    step();
    for (int k = 0; k < 5; k++) begin
      n_total++; if (bus.IF_ID_vld !== 1'b1) $display("FAIL stream_vld_%0d: got %b exp 1", k, bus.IF_ID_vld); else n_pass++;
      n_total++; if (bus.IF_ID_pc !== 32'(4 * k)) $display("FAIL stream_pc_%0d: got %h exp %h", k, bus.IF_ID_pc, 32'(4 * k)); else n_pass++;
      n_total++; if (bus.IF_ID_inst !== 32'(4 * k + 1)) $display("FAIL stream_inst_%0d: got %h exp %h", k, bus.IF_ID_inst, 32'(4 * k + 1)); else n_pass++;
      step();
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(); step(); step();
    hold_IF = 1'b1;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL hold_req: got %b exp 0", bus.imem_req); else n_pass++;
    step();
    hold_IF = 1'b0;
    #1;
    n_total++; if (bus.IF_ID_pc !== 32'h4) $display("FAIL hold_pc: got %h exp 4", bus.IF_ID_pc); else n_pass++;
    n_total++; if (bus.IF_ID_vld !== 1'b1) $display("FAIL hold_vld: got %b exp 1", bus.IF_ID_vld); else n_pass++;
    n_total++; if (dbg_state !== 2'd2) $display("FAIL hold_state: got %0d exp 2", dbg_state); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL hold_state_req: got %b exp 0", bus.imem_req); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'h8) $display("FAIL skid_pc: got %h exp 8", bus.IF_ID_pc); else n_pass++;
    n_total++; if (bus.IF_ID_inst !== 32'h9) $display("FAIL skid_inst: got %h exp 9", bus.IF_ID_inst); else n_pass++;
    n_total++; if (bus.IF_ID_vld !== 1'b1) $display("FAIL skid_vld: got %b exp 1", bus.IF_ID_vld); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'hC) $display("FAIL hold_resume_addr: got %h exp c", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL hold_gap_vld: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'hC) $display("FAIL hold_next_pc: got %h exp c", bus.IF_ID_pc); else n_pass++;
    n_total++; if (bus.IF_ID_inst !== 32'hD) $display("FAIL hold_next_inst: got %h exp d", bus.IF_ID_inst); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    jmp_vld = 1'b1; jmp_addr = 32'h100;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL jmp_req: got %b exp 0", bus.imem_req); else n_pass++;
    step();
    jmp_vld = 1'b0;
    #1;
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL jmp_flush_vld: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    n_total++; if (bus.IF_ID_inst !== NOP) $display("FAIL jmp_flush_inst: got %h exp %h", bus.IF_ID_inst, NOP); else n_pass++;
    n_total++; if (bus.IF_ID_pc !== 32'hC) $display("FAIL jmp_flush_pc: got %h exp c", bus.IF_ID_pc); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL jmp_tgt_req: got %b exp 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h100) $display("FAIL jmp_tgt_addr: got %h exp 100", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL jmp_bubble2: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'h100) $display("FAIL jmp_pc: got %h exp 100", bus.IF_ID_pc); else n_pass++;
    n_total++; if (bus.IF_ID_inst !== 32'h101) $display("FAIL jmp_inst: got %h exp 101", bus.IF_ID_inst); else n_pass++;
    n_total++; if (bus.IF_ID_vld !== 1'b1) $display("FAIL jmp_vld: got %b exp 1", bus.IF_ID_vld); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'h104) $display("FAIL jmp_pc2: got %h exp 104", bus.IF_ID_pc); else n_pass++;
  endtask

  task automatic test_hold_redirect();
    do_reset();
    step(); step(); step();
    hold_IF = 1'b1;
    step();
    jmp_vld = 1'b1; jmp_addr = 32'h40;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL hj_req: got %b exp 0", bus.imem_req); else n_pass++;
    step();
    hold_IF = 1'b0; jmp_vld = 1'b0;
    #1;
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL hj_flush_vld: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL hj_tgt_req: got %b exp 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h40) $display("FAIL hj_tgt_addr: got %h exp 40", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL hj_bubble2: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'h40) $display("FAIL hj_pc: got %h exp 40", bus.IF_ID_pc); else n_pass++;
    n_total++; if (bus.IF_ID_inst !== 32'h41) $display("FAIL hj_inst: got %h exp 41", bus.IF_ID_inst); else n_pass++;
  endtask

  task automatic test_gnt_stall();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bus.imem_req !== 1'b1) $display("FAIL stall_req_%0d: got %b exp 1", i, bus.imem_req); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h20) $display("FAIL stall_addr_%0d: got %h exp 20", i, bus.imem_addr); else n_pass++;
      n_total++; if (bus.IF_ID_vld !== (i < 2)) $display("FAIL stall_vld_%0d: got %b exp %b", i, bus.IF_ID_vld, (i < 2)); else n_pass++;
      step();
    end
    bus.imem_gnt = 1'b1;
    #1;
    n_total++; if (bus.imem_addr !== 32'h20) $display("FAIL stall_resume_addr: got %h exp 20", bus.imem_addr); else n_pass++;
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL stall_bubble: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    step();
    n_total++; if (bus.imem_addr !== 32'h24) $display("FAIL stall_next_addr: got %h exp 24", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'h20) $display("FAIL stall_pc: got %h exp 20", bus.IF_ID_pc); else n_pass++;
    n_total++; if (bus.IF_ID_inst !== 32'h21) $display("FAIL stall_inst: got %h exp 21", bus.IF_ID_inst); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    jmp_vld = 1'b1; jmp_addr = 32'hFFFF_FFFC;
    step();
    jmp_vld = 1'b0;
    #1;
    n_total++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h exp fffffffc", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_addr1: got %h exp 0", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h exp fffffffc", bus.IF_ID_pc); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_pc !== 32'h0) $display("FAIL wrap_pc_next: got %h exp 0", bus.IF_ID_pc); else n_pass++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    step(); step(); step();
    rst = 1'b1;
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL mid_rst_req: got %b exp 0", bus.imem_req); else n_pass++;
    step();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL mid_rst_vld: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    n_total++; if (bus.IF_ID_pc !== 32'h0) $display("FAIL mid_rst_pc: got %h exp 0", bus.IF_ID_pc); else n_pass++;
    n_total++; if (dbg_state !== 2'd0) $display("FAIL mid_rst_state: got %0d exp 0", dbg_state); else n_pass++;
    step();
    n_total++; if (bus.IF_ID_vld !== 1'b0) $display("FAIL stray_rsp_vld: got %b exp 0", bus.IF_ID_vld); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL mid_rst_addr: got %h exp 0", bus.imem_addr); else n_pass++;
    step(); step();
    n_total++; if (bus.IF_ID_inst !== 32'h1) $display("FAIL mid_rst_first_inst: got %h exp 1", bus.IF_ID_inst); else n_pass++;
  endtask

  task automatic test_misalign();
    do_reset();
    jmp_vld = 1'b1; jmp_addr = 32'h102;
    step();
    jmp_vld = 1'b0;
    #1;
`ifdef IF_MISALIGN_CHK_EN
    n_total++; if (if_misalign !== 1'b1) $display("FAIL misalign_set: got %b exp 1", if_misalign); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h100) $display("FAIL misalign_addr: got %h exp 100", bus.imem_addr); else n_pass++;
    step();
    n_total++; if (if_misalign !== 1'b0) $display("FAIL misalign_clr: got %b exp 0", if_misalign); else n_pass++;
`else
    n_total++; if (bus.imem_addr !== 32'h102) $display("FAIL misalign_passthru: got %h exp 102", bus.imem_addr); else n_pass++;
`endif
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_hold_redirect();
    test_gnt_stall();
    test_wrap();
    test_reset_midop();
    test_misalign();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
